// File: rtl/signed_minmax_track.sv
// signed_minmax_track
//
// Streaming signed 16-bit extremum tracker. Consumes a batch of
// two's-complement words over a valid/ready handshake. At the end of the
// batch it presents the signed minimum, the signed maximum and the beat count.
//
// The signed less-than rule is the one the datapath comparator uses:
//   - If the sign bits differ, the operand with bit 15 set is smaller.
//   - If the sign bits are equal, the 16-bit words are compared unsigned.
//
// Optional feature macro: MINMAX_INDEX_EN
//   When defined, out_min_idx/out_max_idx report the 0-based beat index of
//   the first occurrence of each extremum.
//
// Parameters
//   COUNT_W      width of the beat counter (saturates at 2^COUNT_W-1)
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   in_valid     input beat valid
//   in_ready     block can accept a beat (held 0 while reset is low)
//   in_data      two's-complement sample
//   in_last      final beat of batch, qualified by in_valid
//   out_valid    batch result valid
//   out_ready    downstream accepts result
//   out_min      signed minimum of batch
//   out_max      signed maximum of batch
//   out_count    beats in batch, saturating
//   out_min_idx  index of first minimum   (MINMAX_INDEX_EN only)
//   out_max_idx  index of first maximum   (MINMAX_INDEX_EN only)

module signed_minmax_track #(
    parameter int COUNT_W = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [15:0]        in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [15:0]        out_min,
    output logic signed [15:0]        out_max,
    output logic [COUNT_W-1:0]        out_count
`ifdef MINMAX_INDEX_EN
    ,
    output logic [COUNT_W-1:0]        out_min_idx,
    output logic [COUNT_W-1:0]        out_max_idx
`endif
);

    localparam int DATA_W = 16;
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [DATA_W-1:0] min_q;
    logic signed [DATA_W-1:0] max_q;
    logic [COUNT_W-1:0]       count_q;
`ifdef MINMAX_INDEX_EN
    logic [COUNT_W-1:0]       min_idx_q;
    logic [COUNT_W-1:0]       max_idx_q;
`endif

    logic accept;
    logic release_result;

    // Datapath signed less-than: a differing sign bit decides outright,
    // otherwise the plain unsigned ordering of the words is the signed order.
    function automatic logic signed_lt(input logic signed [DATA_W-1:0] a,
                                       input logic signed [DATA_W-1:0] b);
        if (a[DATA_W-1] != b[DATA_W-1]) begin
            return a[DATA_W-1];
        end
        return $unsigned(a) < $unsigned(b);
    endfunction

    // Saturating increment of the beat counter.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
        if (c == COUNT_MAX) begin
            return c;
        end
        return c + 1'b1;
    endfunction

    // Handshake decodes. in_ready comes from the registered state only; the
    // reset term keeps it low while the block is held in reset.
    assign in_ready       = reset && (state != HOLD);
    assign out_valid      = (state == HOLD);
    assign accept         = in_valid && in_ready;
    assign release_result = out_valid && out_ready;

    assign out_min   = min_q;
    assign out_max   = max_q;
    assign out_count = count_q;
`ifdef MINMAX_INDEX_EN
    assign out_min_idx = min_idx_q;
    assign out_max_idx = max_idx_q;
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY, ACCUM: begin
                if (accept) begin
                    state_nxt = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Accumulators. The first beat of a batch seeds min/max. Later beats
    // replace them only on a strict compare, so ties keep the first occurrence.
    // The index of the current beat equals the number of beats already held.
    // That count saturates, so the index stops advancing together with it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            min_q     <= '0;
            max_q     <= '0;
            count_q   <= '0;
`ifdef MINMAX_INDEX_EN
            min_idx_q <= '0;
            max_idx_q <= '0;
`endif
        end else if (accept) begin
            if (state == EMPTY) begin
                min_q     <= in_data;
                max_q     <= in_data;
                count_q   <= COUNT_W'(1);
`ifdef MINMAX_INDEX_EN
                min_idx_q <= '0;
                max_idx_q <= '0;
`endif
            end else begin
                if (signed_lt(in_data, min_q)) begin
                    min_q     <= in_data;
`ifdef MINMAX_INDEX_EN
                    min_idx_q <= count_q;
`endif
                end
                if (signed_lt(max_q, in_data)) begin
                    max_q     <= in_data;
`ifdef MINMAX_INDEX_EN
                    max_idx_q <= count_q;
`endif
                end
                count_q <= sat_inc(count_q);
            end
        end else if (release_result) begin
            // Result consumed: clear so the next batch starts from a clean state.
            min_q     <= '0;
            max_q     <= '0;
            count_q   <= '0;
`ifdef MINMAX_INDEX_EN
            min_idx_q <= '0;
            max_idx_q <= '0;
`endif
        end
    end

endmodule
